// File: rtl/pc_src_pkg.sv
// Shared RV32I opcode and branch funct3 encodings used by the branch/jump resolution unit.
package pc_src_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/pc_src_branch_cmp.sv
// Conditional-branch evaluation: maps funct3 and the ALU flags to taken / illegal-funct3.
module branch_cmp
    import pc_src_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       bad_f3
);

    always_comb begin
        taken  = 1'b0;
        bad_f3 = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: bad_f3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_src.sv
// Branch/jump resolution for the execute stage: next-PC select, registered flush, illegal flag.
// Optional statistics counters are compiled in with `define PC_SRC_STATS_EN.
module pc_src
    import pc_src_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boj,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    input  logic [31:0] instr,
    output logic        PC_src,
    output logic        flush_q,
    output logic        illegal
`ifdef PC_SRC_STATS_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] taken_cnt
`endif
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_branch;
    logic       is_jump;
    logic       br_taken;
    logic       br_bad_f3;
    logic       unused_instr_bits;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

    // Register, immediate and rd fields never influence the redirect decision.
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    branch_cmp u_branch_cmp (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (br_taken),
        .bad_f3 (br_bad_f3)
    );

    always_comb begin
        PC_src  = 1'b0;
        illegal = 1'b0;
        if (boj) begin
            if (is_branch) begin
                PC_src  = br_taken & ~br_bad_f3;
                illegal = br_bad_f3;
            end else if (is_jump) begin
                PC_src  = 1'b1;
            end else begin
                illegal = 1'b1;
            end
        end
    end

    // Execute -> flush stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flush_q <= 1'b0;
        else        flush_q <= PC_src;
    end

`ifdef PC_SRC_STATS_EN
    logic [31:0] branch_cnt_r;
    logic [31:0] taken_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_r <= 32'd0;
            taken_cnt_r  <= 32'd0;
        end else begin
            if (boj && !illegal) branch_cnt_r <= branch_cnt_r + 32'd1;
            if (PC_src)          taken_cnt_r  <= taken_cnt_r + 32'd1;
        end
    end

    assign branch_cnt = branch_cnt_r;
    assign taken_cnt  = taken_cnt_r;
`endif

endmodule

// File: tb/tb_pc_src.sv
// Self-checking bench for pc_src; stats scenarios run when PC_SRC_STATS_EN is defined.
module tb_pc_src;

    logic        clk;
    logic        rst_n;
    logic        boj;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic [31:0] instr;
    logic        PC_src;
    logic        flush_q;
    logic        illegal;
`ifdef PC_SRC_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0] comb_q[$];
    logic       flush_exp_q[$];

    pc_src dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .boj        (boj),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .instr      (instr),
        .PC_src     (PC_src),
        .flush_q    (flush_q),
        .illegal    (illegal)
`ifdef PC_SRC_STATS_EN
        ,
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: truth-table lookup over {opcode class, funct3, flags}.
    function automatic logic [1:0] model(input logic b, input logic [31:0] i,
                                         input logic z, input logic l, input logic lu);
        logic [2:0] f;
        logic [7:0] cond;
        f = i[14:12];
        // index = funct3: BEQ,BNE,-,-,BLT,BGE,BLTU,BGEU
        cond = {~lu, lu, ~l, l, 1'b0, 1'b0, ~z, z};
        if (!b) return 2'b00;
        if (i[6:0] == 7'h6F || i[6:0] == 7'h67) return 2'b10;
        if (i[6:0] != 7'h63) return 2'b01;
        if (f == 3'd2 || f == 3'd3) return 2'b01;
        return {cond[f], 1'b0};
    endfunction

    task automatic step(input logic b, input logic [31:0] i, input logic z,
                        input logic l, input logic lu,
                        input logic e_pc, input logic e_ill, input string name);
        logic [1:0] e;
        logic       ef;
        @(negedge clk);
        boj = b; instr = i; zero = z; lt = l; ltu = lu;
        comb_q.push_back({e_pc, e_ill});
        flush_exp_q.push_back(e_pc);
        #1;
        e = comb_q.pop_front();
        checks++;
        if (PC_src !== e[1]) begin
            errors++;
            $display("FAIL %s PC_src got %b expected %b", name, PC_src, e[1]);
        end
        checks++;
        if (illegal !== e[0]) begin
            errors++;
            $display("FAIL %s illegal got %b expected %b", name, illegal, e[0]);
        end
        @(posedge clk);
        #1;
        ef = flush_exp_q.pop_front();
        checks++;
        if (flush_q !== ef) begin
            errors++;
            $display("FAIL %s flush_q got %b expected %b", name, flush_q, ef);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        boj = 1'b0; instr = 32'h0000_0013; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        boj = 1'b1; instr = 32'h008002EF; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        #12;
        checks++;
        if (flush_q !== 1'b0) begin
            errors++; $display("FAIL reset_flush got %b expected 0", flush_q);
        end
        checks++;
        if (PC_src !== 1'b1) begin
            errors++; $display("FAIL reset_comb_pc got %b expected 1", PC_src);
        end
`ifdef PC_SRC_STATS_EN
        checks++;
        if (branch_cnt !== 32'd0 || taken_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d expected 0/0", branch_cnt, taken_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (flush_q !== 1'b1) begin
            errors++; $display("FAIL reset_release_flush got %b expected 1", flush_q);
        end
    endtask

    task automatic test_beq_bne();
        step(1, 32'h00628C63, 0, 0, 0, 0, 0, "beq_z0");
        step(1, 32'h00628C63, 1, 0, 0, 1, 0, "beq_z1");
        step(1, 32'h00629A63, 0, 0, 0, 1, 0, "bne_z0");
        step(1, 32'h00629A63, 1, 0, 0, 0, 0, "bne_z1");
    endtask

    task automatic test_blt_bge();
        step(1, 32'h0062C863, 0, 0, 1, 0, 0, "blt_l0");
        step(1, 32'h0062C863, 0, 1, 0, 1, 0, "blt_l1");
        step(1, 32'h0062D663, 0, 0, 1, 1, 0, "bge_l0");
        step(1, 32'h0062D663, 0, 1, 0, 0, 0, "bge_l1");
    endtask

    task automatic test_bltu_bgeu();
        step(1, 32'h0052E863, 0, 1, 0, 0, 0, "bltu_u0");
        step(1, 32'h0052E863, 0, 0, 1, 1, 0, "bltu_u1");
        step(1, 32'h0062F263, 1, 1, 0, 1, 0, "bgeu_u0");
        step(1, 32'h0062F263, 1, 1, 1, 0, 0, "bgeu_u1");
    endtask

    task automatic test_gating_illegal();
        step(0, 32'h0062C863, 0, 1, 0, 0, 0, "gate_blt");
        step(0, 32'h008002EF, 1, 1, 1, 0, 0, "gate_jal");
        step(1, 32'h0062A063, 1, 1, 1, 0, 1, "illegal_f3_010");
        step(1, 32'h0062B063, 1, 1, 1, 0, 1, "illegal_f3_011");
        step(1, 32'h00000013, 1, 1, 1, 0, 1, "illegal_opcode");
        step(1, 32'h100302E7, 0, 0, 0, 1, 0, "jalr");
        step(1, 32'hFFFFFFEF, 0, 1, 1, 1, 0, "jal_high_bits");
    endtask

    task automatic test_back_to_back();
        step(1, 32'h008002EF, 0, 0, 0, 1, 0, "b2b_jal");
        step(1, 32'h00628C63, 0, 0, 0, 0, 0, "b2b_beq_nt");
        step(1, 32'h100302E7, 0, 0, 0, 1, 0, "b2b_jalr");
        // async reset mid-operation clears flush_q without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (flush_q !== 1'b0) begin
            errors++; $display("FAIL midop_reset_flush got %b expected 0", flush_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0]  ops [4] = '{7'h63, 7'h6F, 7'h67, 7'h33};
        logic [31:0] i;
        logic [1:0]  e;
        logic        b, z, l, lu;
        for (int n = 0; n < 24; n++) begin
            i = $urandom;
            i[6:0] = ops[$urandom_range(0, 3)];
            b  = 1'($urandom_range(0, 3) != 0);
            z  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            lu = 1'($urandom_range(0, 1));
            e = model(b, i, z, l, lu);
            step(b, i, z, l, lu, e[1], e[0], "random");
        end
    endtask

`ifdef PC_SRC_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (branch_cnt !== 32'd0 || taken_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_reset got %0d/%0d expected 0/0", branch_cnt, taken_cnt);
        end
        idle();
        rst_n = 1'b1;
        step(1, 32'h00628C63, 1, 0, 0, 1, 0, "st_beq_t");
        step(1, 32'h00629A63, 1, 0, 0, 0, 0, "st_bne_nt");
        step(1, 32'h0062C863, 0, 1, 0, 1, 0, "st_blt_t");
        step(1, 32'h0062D663, 0, 1, 0, 0, 0, "st_bge_nt");
        step(1, 32'h0052E863, 0, 0, 1, 1, 0, "st_bltu_t");
        step(1, 32'h0062F263, 0, 0, 1, 0, 0, "st_bgeu_nt");
        step(1, 32'h100302E7, 0, 0, 0, 1, 0, "st_jalr");
        step(1, 32'h0062A063, 0, 0, 0, 0, 1, "st_illegal");
        step(0, 32'h008002EF, 0, 0, 0, 0, 0, "st_gated");
        idle();
        @(posedge clk);
        #1;
        checks++;
        if (branch_cnt !== 32'd7) begin
            errors++; $display("FAIL stats_branch_cnt got %0d expected 7", branch_cnt);
        end
        checks++;
        if (taken_cnt !== 32'd4) begin
            errors++; $display("FAIL stats_taken_cnt got %0d expected 4", taken_cnt);
        end
        @(negedge clk);
        force dut.branch_cnt_r = 32'hFFFF_FFFF;
        force dut.taken_cnt_r  = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt_r;
        release dut.taken_cnt_r;
        step(1, 32'h008002EF, 0, 0, 0, 1, 0, "st_wrap_jal");
        checks++;
        if (branch_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_branch_wrap got %0d expected 0", branch_cnt);
        end
        checks++;
        if (taken_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_taken_wrap got %0d expected 0", taken_cnt);
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_beq_bne();
        test_blt_bge();
        test_bltu_bgeu();
        test_gating_illegal();
        test_back_to_back();
        test_random();
`ifdef PC_SRC_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
